fxp_mult_pipe: RTL and testbench

Pipelined, parametrised signed fixed-point multiplier for the SPGD datapath. It is the registered successor to the team's combinational multiplier wrapper.
- Adds a valid/ready stream handshake with backpressure and a configurable latency.
- Rounds or truncates under runtime control, and reports overflow per sample plus a sticky flag.
- Optional saturation.
- Sits between the gradient/perturbation arithmetic stages and the accumulators.

---
 rtl/fxp_mult_pipe.sv | 119 +++++++++++
 tb/tb_fxp_mult_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fxp_mult_pipe.sv
// fxp_mult_pipe: pipelined signed fixed-point multiplier with round/truncate, overflow flags and optional saturation (SPGD_MULT_SAT_EN)
module fxp_mult_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int INT_WIDTH  = 16,
    parameter int OUT_INT    = 16,
    parameter int OUT_FRAC   = 16,
    parameter int BIT_SHIFT  = 0,
    parameter int LATENCY    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [DATA_WIDTH-1:0]       a,
    input  logic signed [DATA_WIDTH-1:0]       b,
    input  logic                               round_en,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [OUT_INT+OUT_FRAC-1:0] p,
    output logic                               ovf,
    output logic                               ovf_sticky,
    input  logic                               ovf_clr
);
    localparam int FRAC = DATA_WIDTH - INT_WIDTH;
    localparam int OW   = OUT_INT + OUT_FRAC;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int L    = 2 * FRAC - OUT_FRAC + BIT_SHIFT;
    localparam int EW   = ((PW + 1 > L + OW) ? PW + 1 : L + OW) + 1;
    localparam int NM   = LATENCY - 1;
    localparam logic signed [EW-1:0] RC = (L >= 1) ? (EW'(1) << (L - 1)) : '0;

    if (L < 0) begin : g_bad_lsb
        $error("fxp_mult_pipe: result LSB index is negative");
    end
    if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
        $error("fxp_mult_pipe: LATENCY must be in 2..8");
    end

    logic                         ce;
    logic                         v1_q, v1_d, r1_q, r1_d;
    logic signed [DATA_WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic signed [PW-1:0]         prod_q [NM];
    logic signed [PW-1:0]         prod_d [NM];
    logic                         vm_q [NM];
    logic                         vm_d [NM];
    logic                         rm_q [NM];
    logic                         rm_d [NM];
    logic signed [PW-1:0]         mul;
    logic signed [EW-1:0]         rnd, shf;
    logic [EW-OW:0]               upper;
    logic                         ovf_c;
    logic signed [OW-1:0]         p_c, p_d, p_q;
    logic                         ovf_d, ovf_q, out_valid_d, out_valid_q, sticky_d, sticky_q;

    always_comb begin
        ce = !out_valid_q || out_ready;
        v1_d = ce ? in_valid : v1_q;
        a1_d = ce ? a : a1_q;
        b1_d = ce ? b : b1_q;
        r1_d = ce ? round_en : r1_q;
        mul = PW'(a1_q) * PW'(b1_q);
        prod_d[0] = ce ? mul : prod_q[0];
        vm_d[0] = ce ? v1_q : vm_q[0];
        rm_d[0] = ce ? r1_q : rm_q[0];
        for (int i = 1; i < NM; i++) begin
            prod_d[i] = ce ? prod_q[i-1] : prod_q[i];
            vm_d[i] = ce ? vm_q[i-1] : vm_q[i];
            rm_d[i] = ce ? rm_q[i-1] : rm_q[i];
        end
        // headroom above the result keeps the rounding carry visible to the overflow check
        rnd = EW'(prod_q[NM-1]) + (rm_q[NM-1] ? RC : '0);
        shf = rnd >>> L;
        upper = shf[EW-1:OW-1];
        ovf_c = !((&upper) || !(|upper));
`ifdef SPGD_MULT_SAT_EN
        p_c = ovf_c ? (prod_q[NM-1][PW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}}) : shf[OW-1:0];
`else
        p_c = shf[OW-1:0];
`endif
        out_valid_d = ce ? vm_q[NM-1] : out_valid_q;
        p_d = ce ? p_c : p_q;
        ovf_d = ce ? ovf_c : ovf_q;
        sticky_d = ovf_clr ? 1'b0 : (out_valid_q && out_ready && ovf_q) ? 1'b1 : sticky_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            for (int i = 0; i < NM; i++) vm_q[i] <= 1'b0;
            out_valid_q <= 1'b0;
            p_q <= '0;
            ovf_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            for (int i = 0; i < NM; i++) vm_q[i] <= vm_d[i];
            out_valid_q <= out_valid_d;
            p_q <= p_d;
            ovf_q <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        a1_q <= a1_d;
        b1_q <= b1_d;
        r1_q <= r1_d;
        for (int i = 0; i < NM; i++) begin
            prod_q[i] <= prod_d[i];
            rm_q[i] <= rm_d[i];
        end
    end

    assign in_ready   = ce;
    assign out_valid  = out_valid_q;
    assign p          = p_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb_fxp_mult_pipe: directed checks of fxp_mult_pipe at default parameters (LATENCY 3, Q16.16)
module tb_fxp_mult_pipe;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, round_en, out_valid, out_ready, ovf, ovf_sticky, ovf_clr;
    logic [31:0] a, b, p;
    int vectors = 0;
    int miscompares = 0;
    logic [32:0] exp_q [$];
    logic [32:0] e;
    logic [31:0] hold;
    logic acc, del, stall;
    int sent, got, cyc;

`ifdef SPGD_MULT_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_NEG = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_POS = 32'h9C40_0000;
    localparam logic [31:0] OVF_NEG = 32'h63C0_0000;
`endif

    always #5 clk = ~clk;

    fxp_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .round_en(round_en), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic r);
        longint pr, q;
        logic ov;
        logic [31:0] res;
        pr = longint'($signed(x)) * longint'($signed(y));
        q = (pr + (r ? 64'sd32768 : 64'sd0)) >>> 16;
        ov = (q > 64'sd2147483647) || (q < -64'sd2147483648);
        res = q[31:0];
`ifdef SPGD_MULT_SAT_EN
        if (ov) res = (pr < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {ov, res};
    endfunction

    task automatic run_one(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                           input logic xr, input logic [31:0] ep, input logic eo);
        a = xa;
        b = xb;
        round_en = xr;
        in_valid = 1'b1;
        chk({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            tick();
            chk({tag, " early valid"}, out_valid, 0);
        end
        tick();
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " p"}, p, ep);
        chk({tag, " ovf"}, ovf, eo);
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; round_en = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        tick();
        tick();
        chk("rst out_valid", out_valid, 0);
        chk("rst p", p, 0);
        chk("rst ovf", ovf, 0);
        chk("rst sticky", ovf_sticky, 0);
        rst = 1'b0;
        tick();
        chk("in_ready after rst", in_ready, 1);

        run_one("basic", 32'h0002_0000, 32'h0003_8000, 1'b0, 32'h0007_0000, 1'b0);
        chk("sticky clean", ovf_sticky, 0);
        run_one("sign", 32'hFFFE_8000, 32'h0002_0000, 1'b0, 32'hFFFD_0000, 1'b0);
        run_one("trunc", 32'h0000_0001, 32'h0000_8000, 1'b0, 32'h0000_0000, 1'b0);
        run_one("round", 32'h0000_0001, 32'h0000_8000, 1'b1, 32'h0000_0001, 1'b0);
        run_one("neg trunc", 32'hFFFF_FFFF, 32'h0000_8000, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_one("neg round", 32'hFFFF_FFFF, 32'h0000_8000, 1'b1, 32'h0000_0000, 1'b0);
        run_one("ovf pos", 32'h00C8_0000, 32'h00C8_0000, 1'b0, OVF_POS, 1'b1);
        chk("sticky set", ovf_sticky, 1);
        run_one("ovf neg", 32'hFF38_0000, 32'h00C8_0000, 1'b0, OVF_NEG, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("sticky clr", ovf_sticky, 0);

        a = 32'h00C8_0000; b = 32'h00C8_0000; round_en = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("clr prio valid", out_valid, 1);
        chk("clr prio ovf", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr priority", ovf_sticky, 0);

        sent = 0; got = 0; cyc = 0; stall = 1'b0; hold = '0;
        a = $urandom; b = $urandom; round_en = 1'($urandom_range(0, 1)); in_valid = 1'b1;
        while (got < 20 && cyc < 1000) begin
            out_ready = (cyc % 6 == 0);
            #1;
            if (stall) begin
                chk("stall valid", out_valid, 1);
                chk("stall p", p, hold);
            end
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            stall = out_valid && !out_ready;
            hold = p;
            if (acc) exp_q.push_back(model(a, b, round_en));
            if (del) begin
                chk("bp nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bp p", p, e[31:0]);
                    chk("bp ovf", ovf, e[32]);
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 20) begin
                    a = $urandom; b = $urandom; round_en = 1'($urandom_range(0, 1));
                end else in_valid = 1'b0;
            end
        end
        chk("bp delivered", got, 20);
        chk("bp drained", exp_q.size(), 0);

        out_ready = 1'b1;
        tick();
        a = 32'h0001_0000; b = 32'h0001_0000; round_en = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'h0002_0000;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("post-rst quiet", out_valid, 0);
            tick();
        end
        chk("post-rst in_ready", in_ready, 1);
        run_one("after rst", 32'h0002_0000, 32'h0003_8000, 1'b0, 32'h0007_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
